mdu_sched: RTL and testbench

Sequencer for an iterative multiply/divide unit attached to the execute stage. It accepts one RV64M-style operation from decode through a valid/ready handshake, runs a shift-add multiply or restoring divide one bit per cycle under a counter-driven FSM, and holds the result until the memory-stage side accepts it. `busy` stalls the front end while an operation is in flight. Single-cycle ALU operations bypass this block entirely.

---
 rtl/mdu_sched.sv | 166 ++++++++++++++++
 tb/tb_mdu_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// mdu_sched: sequencer for an iterative shift-add multiply / restoring divide unit.
// Build option MDU_EARLY_OUT_EN: trivial MUL/DIVU/REMU operands complete at accept.
module mdu_sched #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic [4:0]       req_dst_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_result_o,
    output logic [4:0]       resp_dst_o,
    output logic             busy_o
);
    // state | meaning
    // IDLE  | waiting for an op, req_ready high
    // BUSY  | one multiply/divide iteration per cycle
    // DONE  | result held until downstream takes it
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       dst_q, dst_d;
    logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, res_q, res_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;

    logic             req_div, req_sdiv, req_rsvd, a_sgn, b_sgn, div_zero, div_ovf, early;
    logic [WIDTH-1:0] a_mag, b_mag, early_res;

    assign req_div  = req_op_i[2];
    assign req_sdiv = req_op_i[2] & ~req_op_i[0];
    assign req_rsvd = ~req_op_i[2] & (req_op_i[1:0] != 2'b00);
    assign a_sgn    = req_sdiv & req_a_i[WIDTH-1];
    assign b_sgn    = req_sdiv & req_b_i[WIDTH-1];
    assign a_mag    = a_sgn ? -req_a_i : req_a_i;
    assign b_mag    = b_sgn ? -req_b_i : req_b_i;
    assign div_zero = req_div & (req_b_i == '0);
    assign div_ovf  = req_sdiv & (req_a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&req_b_i);

    always_comb begin
        early     = 1'b0;
        early_res = '0;
`ifdef MDU_EARLY_OUT_EN
        if (req_op_i == 3'b000 && (req_a_i == '0 || req_b_i == '0)) begin
            early = 1'b1;
        end else if (req_op_i == 3'b101 && req_a_i < req_b_i) begin
            early = 1'b1;
        end else if (req_op_i == 3'b111 && req_a_i < req_b_i) begin
            early     = 1'b1;
            early_res = req_a_i;
        end
`endif
    end

    // Divide step: remainder is WIDTH+1 bits wide only transiently, before the compare.
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic [WIDTH-1:0] mul_acc, quo_nx, rem_nx, div_res;

    assign mul_acc = acc_q + (a_q[0] ? b_q : '0);
    assign rem_sh  = {acc_q, a_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, b_q};
    assign quo_nx  = {a_q[WIDTH-2:0], ~rem_sub[WIDTH]};
    assign rem_nx  = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
    assign div_res = op_q[1] ? (rneg_q ? -rem_nx : rem_nx) : (qneg_q ? -quo_nx : quo_nx);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dst_d   = dst_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    dst_d   = req_dst_i;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    acc_d   = '0;
                    a_d     = req_div ? a_mag : req_a_i;
                    b_d     = req_div ? b_mag : req_b_i;
                    qneg_d  = a_sgn ^ b_sgn;
                    rneg_d  = a_sgn;
                    state_d = BUSY;
                    if (req_rsvd) begin
                        res_d   = '0;
                        state_d = DONE;
                    end else if (div_zero) begin
                        res_d   = req_op_i[1] ? req_a_i : '1;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        res_d   = req_op_i[1] ? '0 : req_a_i;
                        state_d = DONE;
                    end else if (early) begin
                        res_d   = early_res;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q[2]) begin
                    acc_d = rem_nx;
                    a_d   = quo_nx;
                end else begin
                    acc_d = mul_acc;
                    a_d   = a_q >> 1;
                    b_d   = b_q << 1;
                end
                if (cnt_q == '0) begin
                    res_d   = op_q[2] ? div_res : mul_acc;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            dst_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign resp_valid_o  = (state_q == DONE);
    assign busy_o        = (state_q != IDLE);
    assign resp_result_o = res_q;
    assign resp_dst_o    = dst_q;
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: scenario tasks for mdu_sched with a response scoreboard checked on each handshake.
module tb_mdu_sched;
    localparam int W = 64;
`ifdef MDU_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 65;
`endif

    logic         clk = 1'b0;
    logic         reset_i = 1'b0, flush_i = 1'b0, req_valid_i = 1'b0, resp_ready_i = 1'b1;
    logic [2:0]   req_op_i = '0;
    logic [W-1:0] req_a_i = '0, req_b_i = '0;
    logic [4:0]   req_dst_i = '0;
    logic         req_ready_o, resp_valid_o, busy_o;
    logic [W-1:0] resp_result_o;
    logic [4:0]   resp_dst_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   dst;
    } exp_t;
    exp_t sb[$];

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    mdu_sched #(.WIDTH(W), .CNT_W(7)) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_dst_i(req_dst_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_result_o(resp_result_o), .resp_dst_o(resp_dst_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: inputs change just after rising edges, so a negedge sample
    // sees exactly what the next rising edge will handshake on.
    always @(negedge clk) begin
        if (reset_i && resp_valid_o && resp_ready_i) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp result=%h dst=%0d required=none", resp_result_o, resp_dst_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (resp_result_o !== e.res) begin
                    bad++;
                    $display("FAIL resp_result got=%h required=%h", resp_result_o, e.res);
                end
                total++;
                if (resp_dst_o !== e.dst) begin
                    bad++;
                    $display("FAIL resp_dst got=%0d required=%0d", resp_dst_o, e.dst);
                end
            end
        end
    end

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb_;
        sa  = a;
        sb_ = b;
        if (op == 3'b000) return a * b;
        if (!op[2]) return '0;
        if (b == '0) return op[1] ? a : '1;
        if (!op[0] && a == MIN_NEG && b == '1) return op[1] ? '0 : a;
        case (op)
            3'b100:  return sa / sb_;
            3'b101:  return a / b;
            3'b110:  return sa % sb_;
            default: return a % b;
        endcase
    endfunction

    function automatic int lat_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (!op[2] && op != 3'b000) return 1;
        if (op[2] && b == '0) return 1;
        if (op[2] && !op[0] && a == MIN_NEG && b == '1) return 1;
        if (op == 3'b000 && (a == '0 || b == '0)) return EO_LAT;
        if (op[0] && op[2] && a < b) return EO_LAT;
        return 65;
    endfunction

    task automatic drive_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [4:0] dst);
        int g = 0;
        while (!req_ready_o && g < 300) begin
            @(posedge clk); #1; g++;
        end
        if (!req_ready_o) begin
            total++; bad++;
            $display("FAIL req_ready_timeout got=0 required=1");
        end
        req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b; req_dst_i = dst;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!resp_valid_o && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!resp_valid_o) n = 999;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 5;
        if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b required=0", resp_valid_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", busy_o); end
        if (resp_result_o !== '0) begin bad++; $display("FAIL rst_result got=%h required=0", resp_result_o); end
        if (resp_dst_o !== '0) begin bad++; $display("FAIL rst_dst got=%0d required=0", resp_dst_o); end
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b required=1", req_ready_o); end
        reset_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int n;
        sb.push_back('{res: 64'hFFFF_FFFF_FFFF_FFFD, dst: 5'd5});
        drive_req(3'b000, '1, 64'd3, 5'd5);
        total += 3;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL mul_busy got=%b required=1", busy_o); end
        if (req_ready_o !== 1'b0) begin bad++; $display("FAIL mul_req_ready got=%b required=0", req_ready_o); end
        wait_valid(n);
        if (n != 65) begin bad++; $display("FAIL mul_latency got=%0d required=65", n); end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, res;
        logic [4:0]   dst;
        int           lat;
    } vec_t;

    task automatic test_div();
        vec_t v[$];
        int n;
        v.push_back('{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 65});
        v.push_back('{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 65});
        v.push_back('{3'b101, 64'd100, 64'd7, 64'd14, 5'd3, 65});
        v.push_back('{3'b111, 64'd100, 64'd7, 64'd2, 5'd4, 65});
        v.push_back('{3'b111, 64'd7, 64'd0, 64'd7, 5'd6, 1});
        v.push_back('{3'b100, MIN_NEG, '1, MIN_NEG, 5'd7, 1});
        v.push_back('{3'b110, MIN_NEG, '1, 64'd0, 5'd8, 1});
        v.push_back('{3'b101, 64'd5, 64'd0, '1, 5'd9, 1});
        v.push_back('{3'b100, 64'd5, 64'd0, '1, 5'd10, 1});
        v.push_back('{3'b010, 64'd5, 64'd3, 64'd0, 5'd11, 1});
        foreach (v[i]) begin
            sb.push_back('{res: v[i].res, dst: v[i].dst});
            drive_req(v[i].op, v[i].a, v[i].b, v[i].dst);
            wait_valid(n);
            total++;
            if (n != v[i].lat) begin
                bad++;
                $display("FAIL div_latency[%0d] got=%0d required=%0d", i, n, v[i].lat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [W-1:0] r;
        logic [4:0] d;
        resp_ready_i = 1'b0;
        sb.push_back('{res: 64'd100, dst: 5'd12});
        drive_req(3'b101, 64'd1000, 64'd10, 5'd12);
        wait_valid(n);
        total++;
        if (n != 65) begin bad++; $display("FAIL bp_latency got=%0d required=65", n); end
        r = resp_result_o;
        d = resp_dst_o;
        repeat (20) begin
            @(posedge clk); #1;
            total += 4;
            if (resp_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b required=1", resp_valid_o); end
            if (resp_result_o !== r) begin bad++; $display("FAIL bp_result got=%h required=%h", resp_result_o, r); end
            if (resp_dst_o !== d) begin bad++; $display("FAIL bp_dst got=%0d required=%0d", resp_dst_o, d); end
            if (req_ready_o !== 1'b0) begin bad++; $display("FAIL bp_req_ready got=%b required=0", req_ready_o); end
        end
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        total += 2;
        if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b required=0", resp_valid_o); end
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b required=1", req_ready_o); end
    endtask

    task automatic test_flush();
        int n;
        int seen = 0;
        drive_req(3'b101, 64'd1000, 64'd3, 5'd13);
        repeat (29) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        req_valid_i = 1'b1; req_op_i = 3'b000; req_a_i = 64'd6; req_b_i = 64'd7; req_dst_i = 5'd9;
        @(posedge clk); #1;
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        total += 3;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b required=0", busy_o); end
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL flush_req_ready got=%b required=1", req_ready_o); end
        if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b required=0", resp_valid_o); end
        repeat (70) begin
            @(posedge clk); #1;
            if (resp_valid_o || busy_o) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL flush_quiet got=%0d required=0", seen); end
        sb.push_back('{res: 64'd42, dst: 5'd9});
        drive_req(3'b000, 64'd6, 64'd7, 5'd9);
        wait_valid(n);
        total++;
        if (n != 65) begin bad++; $display("FAIL flush_mul_latency got=%0d required=65", n); end
        @(posedge clk); #1;
        // An op flushed while its result waits in DONE must vanish too.
        resp_ready_i = 1'b0;
        drive_req(3'b011, 64'd1, 64'd1, 5'd14);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        total++;
        if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL flush_done_valid got=%b required=0", resp_valid_o); end
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy();
        int seen = 0;
        drive_req(3'b101, 64'd100, 64'd7, 5'd15);
        repeat (9) begin @(posedge clk); #1; end
        reset_i = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b1;
        total += 4;
        if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b required=0", resp_valid_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b required=0", busy_o); end
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b required=1", req_ready_o); end
        if (resp_result_o !== '0) begin bad++; $display("FAIL mid_rst_result got=%h required=0", resp_result_o); end
        repeat (70) begin
            @(posedge clk); #1;
            if (resp_valid_o) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL mid_rst_quiet got=%0d required=0", seen); end
    endtask

    task automatic test_early_out();
        int n;
        sb.push_back('{res: 64'd0, dst: 5'd16});
        drive_req(3'b000, 64'd0, 64'd5, 5'd16);
        wait_valid(n);
        total++;
        if (n != EO_LAT) begin bad++; $display("FAIL eo_mul_latency got=%0d required=%0d", n, EO_LAT); end
        @(posedge clk); #1;
        sb.push_back('{res: 64'd0, dst: 5'd17});
        drive_req(3'b101, 64'd3, 64'd9, 5'd17);
        wait_valid(n);
        total++;
        if (n != EO_LAT) begin bad++; $display("FAIL eo_divu_latency got=%0d required=%0d", n, EO_LAT); end
        @(posedge clk); #1;
        sb.push_back('{res: 64'd3, dst: 5'd18});
        drive_req(3'b111, 64'd3, 64'd9, 5'd18);
        wait_valid(n);
        total++;
        if (n != EO_LAT) begin bad++; $display("FAIL eo_remu_latency got=%0d required=%0d", n, EO_LAT); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops[6] = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
        logic [2:0] op;
        logic [W-1:0] a, b;
        logic [4:0] dst;
        int n;
        for (int i = 0; i < 10; i++) begin
            op  = ops[$urandom_range(0, 5)];
            a   = {$urandom, $urandom};
            dst = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 64'($urandom_range(1, 1000));
                2:       begin a = MIN_NEG; b = '1; end
                3:       begin a = 64'($urandom_range(0, 50)); b = 64'($urandom_range(1, 100)); end
                default: b = {$urandom, $urandom};
            endcase
            sb.push_back('{res: model(op, a, b), dst: dst});
            drive_req(op, a, b, dst);
            wait_valid(n);
            total++;
            if (n != lat_model(op, a, b)) begin
                bad++;
                $display("FAIL b2b_latency[%0d] op=%b got=%0d required=%0d", i, op, n, lat_model(op, a, b));
            end
            @(posedge clk); #1;
            total++;
            if (req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b required=1", i, req_ready_o); end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_backpressure();
        test_flush();
        test_reset_mid_busy();
        test_early_out();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_drained got=%0d required=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
